// File: rtl/move_select_sched_pkg.sv
// move_sel_pkg: shared widths, candidate count and FSM encoding for the best-move scheduler
package move_sel_pkg;
    localparam int SCORE_W  = 6;
    localparam int POS_W    = 6;
    localparam int NUM_CAND = 64;
    localparam int CNT_W    = $clog2(NUM_CAND + 1);
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SCAN   = 2'd1,
        RESULT = 2'd2
    } state_t;
endpackage

// File: rtl/move_select_sched_if.sv
// move_select_sched_if: candidate stream, result handshake and status (MOVE_SEL_EARLY_EXIT_EN adds thresh/early_exit)
interface move_select_sched_if;
    import move_sel_pkg::*;
    logic               start;
    logic               abort;
    logic               in_valid;
    logic               in_ready;
    logic [SCORE_W-1:0] in_score;
    logic [POS_W-1:0]   in_pos;
    logic               res_valid;
    logic               res_ack;
    logic [SCORE_W-1:0] best_score;
    logic [POS_W-1:0]   best_pos;
    logic [CNT_W-1:0]   cand_cnt;
    logic               busy;
`ifdef MOVE_SEL_EARLY_EXIT_EN
    logic [SCORE_W-1:0] thresh;
    logic               early_exit;
    modport slave (
        input  start, abort, in_valid, in_score, in_pos, res_ack, thresh,
        output in_ready, res_valid, best_score, best_pos, cand_cnt, busy, early_exit
    );
    modport master (
        output start, abort, in_valid, in_score, in_pos, res_ack, thresh,
        input  in_ready, res_valid, best_score, best_pos, cand_cnt, busy, early_exit
    );
`else
    modport slave (
        input  start, abort, in_valid, in_score, in_pos, res_ack,
        output in_ready, res_valid, best_score, best_pos, cand_cnt, busy
    );
    modport master (
        output start, abort, in_valid, in_score, in_pos, res_ack,
        input  in_ready, res_valid, best_score, best_pos, cand_cnt, busy
    );
`endif
endinterface

// File: rtl/move_select_sched_cmp.sv
// move_cmp: combinational (score, pos) select; b wins ties so later candidates take precedence
module move_cmp
    import move_sel_pkg::*;
(
    input  logic [SCORE_W-1:0] a_score_i,
    input  logic [POS_W-1:0]   a_pos_i,
    input  logic [SCORE_W-1:0] b_score_i,
    input  logic [POS_W-1:0]   b_pos_i,
    output logic [SCORE_W-1:0] y_score_o,
    output logic [POS_W-1:0]   y_pos_o
);
    logic b_wins;
    assign b_wins    = b_score_i >= a_score_i;
    assign y_score_o = b_wins ? b_score_i : a_score_i;
    assign y_pos_o   = b_wins ? b_pos_i : a_pos_i;
endmodule

// File: rtl/move_select_sched.sv
// move_select_sched: serial running-max scheduler over NUM_CAND candidates (optional MOVE_SEL_EARLY_EXIT_EN threshold exit)
module move_select_sched
    import move_sel_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    move_select_sched_if.slave  sif
);
    state_t             state_q, state_d;
    logic [SCORE_W-1:0] best_score_q, best_score_d, y_score;
    logic [POS_W-1:0]   best_pos_q, best_pos_d, y_pos;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               res_valid_q, res_valid_d;
    logic               last, hit;
`ifdef MOVE_SEL_EARLY_EXIT_EN
    logic               early_q, early_d;
    assign hit            = sif.in_score >= sif.thresh;
    assign sif.early_exit = early_q;
`else
    assign hit = 1'b0;
`endif

    move_cmp u_cmp (
        .a_score_i (best_score_q),
        .a_pos_i   (best_pos_q),
        .b_score_i (sif.in_score),
        .b_pos_i   (sif.in_pos),
        .y_score_o (y_score),
        .y_pos_o   (y_pos)
    );

    assign last           = cnt_q == CNT_W'(NUM_CAND - 1);
    assign sif.in_ready   = (state_q == SCAN) && !sif.abort;
    assign sif.res_valid  = res_valid_q;
    assign sif.best_score = best_score_q;
    assign sif.best_pos   = best_pos_q;
    assign sif.cand_cnt   = cnt_q;
    assign sif.busy       = state_q != IDLE;

    // Next-state: scan start/clear, per-transfer max update, abort, result release
    always_comb begin
        state_d      = state_q;
        best_score_d = best_score_q;
        best_pos_d   = best_pos_q;
        cnt_d        = cnt_q;
        res_valid_d  = res_valid_q;
`ifdef MOVE_SEL_EARLY_EXIT_EN
        early_d      = early_q;
`endif
        case (state_q)
            IDLE: if (sif.start && !sif.abort) begin
                state_d      = SCAN;
                best_score_d = '0;
                best_pos_d   = '0;
                cnt_d        = '0;
`ifdef MOVE_SEL_EARLY_EXIT_EN
                early_d      = 1'b0;
`endif
            end
            SCAN: if (sif.abort) begin
                state_d      = IDLE;
                best_score_d = '0;
                best_pos_d   = '0;
                cnt_d        = '0;
            end else if (sif.in_valid) begin
                best_score_d = y_score;
                best_pos_d   = y_pos;
                cnt_d        = cnt_q + 1'b1;
                if (last || hit) begin
                    state_d     = RESULT;
                    res_valid_d = 1'b1;
`ifdef MOVE_SEL_EARLY_EXIT_EN
                    early_d     = hit;
`endif
                end
            end
            RESULT: if (sif.res_ack) begin
                state_d     = IDLE;
                res_valid_d = 1'b0;
`ifdef MOVE_SEL_EARLY_EXIT_EN
                early_d     = 1'b0;
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    // State and datapath registers, asynchronously cleared
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            best_score_q <= '0;
            best_pos_q   <= '0;
            cnt_q        <= '0;
            res_valid_q  <= 1'b0;
`ifdef MOVE_SEL_EARLY_EXIT_EN
            early_q      <= 1'b0;
`endif
        end else begin
            state_q      <= state_d;
            best_score_q <= best_score_d;
            best_pos_q   <= best_pos_d;
            cnt_q        <= cnt_d;
            res_valid_q  <= res_valid_d;
`ifdef MOVE_SEL_EARLY_EXIT_EN
            early_q      <= early_d;
`endif
        end
    end
endmodule
